// File: rtl/pwr_activity_monitor_pkg.sv
// Shared types and constants for the activity-based power monitor.
// Event indices name the core's activity strobes in evt bit order.
package pwr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_e;

    localparam int NUM_EVT_DEF   = 8;
    localparam int W_WIDTH_DEF   = 8;
    localparam int ACC_WIDTH_DEF = 24;
    localparam int WIN_WIDTH_DEF = 16;

    localparam int EVT_RETIRE = 0;
    localparam int EVT_ALU    = 1;
    localparam int EVT_LOAD   = 2;
    localparam int EVT_STORE  = 3;
    localparam int EVT_RFWR   = 4;
    localparam int EVT_BRANCH = 5;
    localparam int EVT_STALL  = 6;
    localparam int EVT_SPARE  = 7;

endpackage

// File: rtl/pwr_activity_monitor_if.sv
// Event/config inputs and valid/ready sample output of the power monitor.
interface pwr_activity_monitor_if
    import pwr_pkg::*;
#(
    parameter int NUM_EVT   = NUM_EVT_DEF,
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int WIN_WIDTH = WIN_WIDTH_DEF
);
    localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

    logic                 en;
    logic [NUM_EVT-1:0]   evt;
    logic [WIN_WIDTH-1:0] win_len;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [W_WIDTH-1:0]   cfg_wdata;
    logic                 smp_valid;
    logic                 smp_ready;
    logic [ACC_WIDTH-1:0] smp_energy;
    logic [WIN_WIDTH-1:0] smp_cycles;
    logic                 smp_sat;
    logic [7:0]           drop_cnt;
    logic                 busy;

    modport master (
        output en, evt, win_len, cfg_we, cfg_idx, cfg_wdata, smp_ready,
        input  smp_valid, smp_energy, smp_cycles, smp_sat, drop_cnt, busy
    );

    modport slave (
        input  en, evt, win_len, cfg_we, cfg_idx, cfg_wdata, smp_ready,
        output smp_valid, smp_energy, smp_cycles, smp_sat, drop_cnt, busy
    );

endinterface

// File: rtl/pwr_activity_monitor_weight_sum.sv
// Combinational masked adder: sums the weight of every asserted event strobe.
module pwr_weight_sum #(
    parameter int NUM_EVT = 8,
    parameter int W_WIDTH = 8,
    parameter int SUM_W   = 11
) (
    input  logic [NUM_EVT-1:0]              evt_i,
    input  logic [NUM_EVT-1:0][W_WIDTH-1:0] weights_i,
    output logic [SUM_W-1:0]                sum_o
);

    // masked accumulation of per-event weights
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < NUM_EVT; i++) begin
            if (evt_i[i]) begin
                sum_o = sum_o + SUM_W'(weights_i[i]);
            end else begin
                sum_o = sum_o;
            end
        end
    end

endmodule

// File: rtl/pwr_activity_monitor.sv
// Windowed weighted activity accumulator; emits one energy sample per window
// through a valid/ready slot and counts windows lost to backpressure.
module pwr_activity_monitor
    import pwr_pkg::*;
#(
    parameter int NUM_EVT   = NUM_EVT_DEF,
    parameter int W_WIDTH   = W_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int WIN_WIDTH = WIN_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    pwr_activity_monitor_if.slave bus
);

    localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
    localparam int SUM_W = W_WIDTH + IDX_W;
    localparam int EXT_W = ((ACC_WIDTH > SUM_W) ? ACC_WIDTH : SUM_W) + 1;
    localparam logic [IDX_W:0] NUM_EVT_L = (IDX_W + 1)'(NUM_EVT);

    fsm_state_e                      state_q, state_d;
    logic [NUM_EVT-1:0][W_WIDTH-1:0] weights_q, weights_d;
    logic [ACC_WIDTH-1:0]            acc_q, acc_d;
    logic [WIN_WIDTH-1:0]            cnt_q, cnt_d;
    logic [WIN_WIDTH-1:0]            win_len_q, win_len_d;
    logic                            sat_q, sat_d;
    logic                            smp_valid_q, smp_valid_d;
    logic [ACC_WIDTH-1:0]            smp_energy_q, smp_energy_d;
    logic [WIN_WIDTH-1:0]            smp_cycles_q, smp_cycles_d;
    logic                            smp_sat_q, smp_sat_d;
    logic [7:0]                      drop_q, drop_d;

    logic [SUM_W-1:0]     evt_sum_s;
    logic [EXT_W-1:0]     acc_ext_s;
    logic                 overflow_s;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic                 sat_next_s;
    logic                 win_end_s;
    logic                 start_ok_s;
    logic                 slot_free_s;

    pwr_weight_sum #(
        .NUM_EVT (NUM_EVT),
        .W_WIDTH (W_WIDTH),
        .SUM_W   (SUM_W)
    ) u_weight_sum (
        .evt_i     (bus.evt),
        .weights_i (weights_q),
        .sum_o     (evt_sum_s)
    );

    // datapath: exact wide add, clamped to the accumulator's all-ones value
    assign acc_ext_s   = EXT_W'(acc_q) + EXT_W'(evt_sum_s);
    assign overflow_s  = acc_ext_s > EXT_W'({ACC_WIDTH{1'b1}});
    assign acc_next_s  = overflow_s ? {ACC_WIDTH{1'b1}} : acc_ext_s[ACC_WIDTH-1:0];
    assign sat_next_s  = sat_q | overflow_s;
    assign win_end_s   = (cnt_q == (win_len_q - WIN_WIDTH'(1)));
    assign start_ok_s  = bus.en && (bus.win_len != '0);
    assign slot_free_s = !smp_valid_q || bus.smp_ready;

    // weight register file write port
    always_comb begin
        weights_d = weights_q;
        if (bus.cfg_we && ({1'b0, bus.cfg_idx} < NUM_EVT_L)) begin
            weights_d[bus.cfg_idx] = bus.cfg_wdata;
        end else begin
            weights_d = weights_q;
        end
    end

    // FSM next state, window accumulation and sample slot
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        win_len_d    = win_len_q;
        sat_d        = sat_q;
        smp_valid_d  = smp_valid_q && !bus.smp_ready;
        smp_energy_d = smp_energy_q;
        smp_cycles_d = smp_cycles_q;
        smp_sat_d    = smp_sat_q;
        drop_d       = drop_q;
        case (state_q)
            IDLE: begin
                if (start_ok_s) begin
                    state_d   = RUN;
                    win_len_d = bus.win_len;
                    acc_d     = '0;
                    cnt_d     = '0;
                    sat_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    // abort wins over a coinciding window end: partial window is dropped
                    state_d = IDLE;
                end else if (win_end_s) begin
                    if (slot_free_s) begin
                        smp_valid_d  = 1'b1;
                        smp_energy_d = acc_next_s;
                        smp_cycles_d = win_len_q;
                        smp_sat_d    = sat_next_s;
                    end else if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end else begin
                        drop_d = drop_q;
                    end
                    if (start_ok_s) begin
                        win_len_d = bus.win_len;
                        acc_d     = '0;
                        cnt_d     = '0;
                        sat_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    acc_d = acc_next_s;
                    cnt_d = cnt_q + WIN_WIDTH'(1);
                    sat_d = sat_next_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            weights_q    <= {NUM_EVT{W_WIDTH'(1)}};
            acc_q        <= '0;
            cnt_q        <= '0;
            win_len_q    <= '0;
            sat_q        <= 1'b0;
            smp_valid_q  <= 1'b0;
            smp_energy_q <= '0;
            smp_cycles_q <= '0;
            smp_sat_q    <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            weights_q    <= weights_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            win_len_q    <= win_len_d;
            sat_q        <= sat_d;
            smp_valid_q  <= smp_valid_d;
            smp_energy_q <= smp_energy_d;
            smp_cycles_q <= smp_cycles_d;
            smp_sat_q    <= smp_sat_d;
            drop_q       <= drop_d;
        end
    end

    assign bus.smp_valid  = smp_valid_q;
    assign bus.smp_energy = smp_energy_q;
    assign bus.smp_cycles = smp_cycles_q;
    assign bus.smp_sat    = smp_sat_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.busy       = (state_q == RUN);

endmodule

// File: tb/tb_pwr_activity_monitor.sv
// Two monitors (24-bit and 8-bit accumulators) share one stimulus stream and are
// compared each cycle against a window-level model using unbounded sums.
module tb_pwr_activity_monitor;

    localparam longint MAX24 = 64'd16777215;
    localparam longint MAX8  = 64'd255;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  evt;
    logic [15:0] win_len;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [7:0]  cfg_wdata;
    logic        ready;

    int checks;
    int failures;

    pwr_activity_monitor_if #(.ACC_WIDTH(24)) bus24 ();
    pwr_activity_monitor_if #(.ACC_WIDTH(8))  bus8 ();

    assign bus24.en = en;        assign bus8.en = en;
    assign bus24.evt = evt;      assign bus8.evt = evt;
    assign bus24.win_len = win_len;     assign bus8.win_len = win_len;
    assign bus24.cfg_we = cfg_we;       assign bus8.cfg_we = cfg_we;
    assign bus24.cfg_idx = cfg_idx;     assign bus8.cfg_idx = cfg_idx;
    assign bus24.cfg_wdata = cfg_wdata; assign bus8.cfg_wdata = cfg_wdata;
    assign bus24.smp_ready = ready;     assign bus8.smp_ready = ready;

    pwr_activity_monitor #(.ACC_WIDTH(24)) u_dut24 (.clk_i(clk), .rst_ni(rst_n), .bus(bus24));
    pwr_activity_monitor #(.ACC_WIDTH(8))  u_dut8  (.clk_i(clk), .rst_ni(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: window progress and the held sample
    bit     m_active;
    int     m_len;
    int     m_n;
    longint m_total;
    int     m_w [8];
    bit     m_valid;
    longint m_smp_total;
    int     m_smp_cycles;
    int     m_drop;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint clampv(input longint t, input longint mx);
        return (t > mx) ? mx : t;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_len = 0; m_n = 0; m_total = 0;
        for (int i = 0; i < 8; i++) m_w[i] = 1;
        m_valid = 1'b0; m_smp_total = 0; m_smp_cycles = 0; m_drop = 0;
    endtask

    task automatic model_step();
        bit     slot_free;
        longint cyc_sum;
        slot_free = !m_valid || ready;
        if (m_valid && ready) m_valid = 1'b0;
        if (m_active) begin
            if (!en) begin
                m_active = 1'b0;
            end else begin
                cyc_sum = 0;
                for (int i = 0; i < 8; i++) if (evt[i]) cyc_sum += m_w[i];
                m_total += cyc_sum;
                m_n++;
                if (m_n == m_len) begin
                    if (slot_free) begin
                        m_valid = 1'b1; m_smp_total = m_total; m_smp_cycles = m_len;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                    if (win_len != 16'd0) begin
                        m_len = int'(win_len); m_n = 0; m_total = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end
        end else if (en && win_len != 16'd0) begin
            m_active = 1'b1; m_len = int'(win_len); m_n = 0; m_total = 0;
        end
        if (cfg_we) m_w[cfg_idx] = int'(cfg_wdata);
    endtask

    task automatic compare_all();
        check_value("valid24",  32'(bus24.smp_valid),  32'(m_valid));
        check_value("valid8",   32'(bus8.smp_valid),   32'(m_valid));
        check_value("energy24", 32'(bus24.smp_energy), 32'(clampv(m_smp_total, MAX24)));
        check_value("energy8",  32'(bus8.smp_energy),  32'(clampv(m_smp_total, MAX8)));
        check_value("cycles24", 32'(bus24.smp_cycles), 32'(m_smp_cycles));
        check_value("cycles8",  32'(bus8.smp_cycles),  32'(m_smp_cycles));
        check_value("sat24",    32'(bus24.smp_sat),    32'(m_smp_total > MAX24));
        check_value("sat8",     32'(bus8.smp_sat),     32'(m_smp_total > MAX8));
        check_value("drop24",   32'(bus24.drop_cnt),   32'(m_drop));
        check_value("drop8",    32'(bus8.drop_cnt),    32'(m_drop));
        check_value("busy24",   32'(bus24.busy),       32'(m_active));
        check_value("busy8",    32'(bus8.busy),        32'(m_active));
    endtask

    // one clock: model follows the edge, outputs checked on the falling edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_weight(input logic [2:0] idx, input logic [7:0] val);
        cfg_we = 1'b1; cfg_idx = idx; cfg_wdata = val;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; en = 1'b0; evt = 8'h00; win_len = 16'd0;
        cfg_we = 1'b0; cfg_idx = 3'd0; cfg_wdata = 8'd0; ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // default weights count raw retire events
        en = 1'b1; win_len = 16'd4; evt = 8'h01; ready = 1'b1;
        ticks(5);
        check_value("t1_valid", 32'(bus24.smp_valid), 32'd1);
        check_value("t1_energy", 32'(bus24.smp_energy), 32'd4);
        check_value("t1_cycles", 32'(bus24.smp_cycles), 32'd4);
        check_value("t1_sat", 32'(bus24.smp_sat), 32'd0);
        en = 1'b0; ticks(2);

        // programmed weights, back-to-back windows
        write_weight(3'd0, 8'd10);
        write_weight(3'd2, 8'd3);
        en = 1'b1; win_len = 16'd2; evt = 8'h00; tick();
        evt = 8'h05; tick();
        evt = 8'h04; tick();
        check_value("t2_energy_a", 32'(bus24.smp_energy), 32'd16);
        check_value("t2_busy_nogap", 32'(bus24.busy), 32'd1);
        evt = 8'h05; tick();
        evt = 8'h04; tick();
        check_value("t2_valid_b", 32'(bus24.smp_valid), 32'd1);
        check_value("t2_energy_b", 32'(bus24.smp_energy), 32'd16);
        en = 1'b0; ticks(2);

        // backpressure: first sample held, later windows dropped
        ready = 1'b0; en = 1'b1; win_len = 16'd2; evt = 8'h02;
        ticks(7);
        check_value("t3_held_energy", 32'(bus24.smp_energy), 32'd2);
        check_value("t3_drop", 32'(bus24.drop_cnt), 32'd2);
        ready = 1'b1; ticks(2);
        check_value("t3_next_valid", 32'(bus24.smp_valid), 32'd1);
        en = 1'b0; ticks(2);

        // saturation on the narrow accumulator only
        for (int i = 0; i < 8; i++) write_weight(3'(i), 8'hFF);
        en = 1'b1; win_len = 16'd4; evt = 8'hFF;
        ticks(5);
        check_value("t4_energy8", 32'(bus8.smp_energy), 32'd255);
        check_value("t4_sat8", 32'(bus8.smp_sat), 32'd1);
        check_value("t4_energy24", 32'(bus24.smp_energy), 32'd8160);
        check_value("t4_sat24", 32'(bus24.smp_sat), 32'd0);
        evt = 8'h00; ticks(4);
        check_value("t4_sat8_clr", 32'(bus8.smp_sat), 32'd0);
        en = 1'b0; ticks(2);

        // en dropped mid-window, then a fresh window
        en = 1'b1; win_len = 16'd8; evt = 8'h01;
        ticks(3);
        en = 1'b0; tick();
        check_value("t5_busy_off", 32'(bus24.busy), 32'd0);
        check_value("t5_no_sample", 32'(bus24.smp_valid), 32'd0);
        en = 1'b1; ticks(9);
        check_value("t5_fresh_energy", 32'(bus24.smp_energy), 32'd2040);

        // async reset mid-window while a sample is pending
        ready = 1'b0; win_len = 16'd3;
        for (int i = 0; i < 12 && !m_valid; i++) tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_value("t6_rst_valid", 32'(bus24.smp_valid), 32'd0);
        check_value("t6_rst_energy", 32'(bus24.smp_energy), 32'd0);
        check_value("t6_rst_busy", 32'(bus24.busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1; win_len = 16'd0; ready = 1'b1;
        ticks(3);
        check_value("t6_len0_idle", 32'(bus24.busy), 32'd0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            en = ($urandom_range(0, 24) != 0);
            evt = 8'($urandom);
            if ($urandom_range(0, 5) == 0) win_len = 16'($urandom_range(0, 6));
            ready = ($urandom_range(0, 2) != 0);
            cfg_we = ($urandom_range(0, 7) == 0);
            cfg_idx = 3'($urandom);
            cfg_wdata = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
        end
        cfg_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
